// File: rtl/lvds_pkg.sv
// Shared definitions for the 7:1 LVDS receive aligner: clock-lane pattern,
// lock FSM states and the VESA/JEIDA bit unmapping.
package lvds_pkg;

  localparam logic [6:0] LVDS_CLK_PATTERN = 7'b1100011;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  typedef struct packed {
    logic        de;
    logic        vs;
    logic        hs;
    logic [23:0] rgb;
  } pixel_t;

  // w = {L3, L2, L1, L0}; L3 bit 6 carries no pixel information
  function automatic pixel_t unmap_vesa(input logic [27:0] w);
    pixel_t p;
    p.de         = w[20];
    p.vs         = w[19];
    p.hs         = w[18];
    p.rgb[23:16] = {w[22:21], w[5:0]};
    p.rgb[15:8]  = {w[24:23], w[11:7], w[6]};
    p.rgb[7:0]   = {w[26:25], w[17:14], w[13:12]};
    return p;
  endfunction

  function automatic pixel_t unmap_jeida(input logic [27:0] w);
    pixel_t p;
    p.de         = w[20];
    p.vs         = w[19];
    p.hs         = w[18];
    p.rgb[23:16] = {w[5:0], w[22:21]};
    p.rgb[15:8]  = {w[11:7], w[6], w[24:23]};
    p.rgb[7:0]   = {w[17:14], w[13:12], w[26:25]};
    return p;
  endfunction

endpackage

// File: rtl/lvds_rx_lane_align.sv
// One LVDS lane: polarity fix, prev/cur sample history and the 7:1 offset
// mux that picks the aligned word out of the 14-bit window.
module lvds_rx_lane_align #(
  parameter bit INV = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  sample,
  input  logic [2:0]  offset,
  output logic [13:0] win14,
  output logic [6:0]  window
);

  logic [6:0] cur_p0;
  logic [6:0] prev_p0;

  // Stage A: sample history, advanced only by valid samples
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cur_p0  <= '0;
      prev_p0 <= '0;
    end else if (en) begin
      prev_p0 <= cur_p0;
      cur_p0  <= sample ^ {7{INV}};
    end
  end

  assign win14 = {prev_p0, cur_p0};

  always_comb begin
    case (offset)
      3'd0:    window = win14[13:7];
      3'd1:    window = win14[12:6];
      3'd2:    window = win14[11:5];
      3'd3:    window = win14[10:4];
      3'd4:    window = win14[9:3];
      3'd5:    window = win14[8:2];
      3'd6:    window = win14[7:1];
      default: window = win14[13:7];
    endcase
  end

endmodule

// File: rtl/lvds_rx_align.sv
// 7:1 LVDS receive word aligner: finds the word boundary on the clock lane,
// tracks lock, realigns the four data lanes and unmaps them to video.
module lvds_rx_align
  import lvds_pkg::*;
#(
  parameter string PROTOCOL  = "VESA",
  parameter bit    CLOCKINV  = 1'b0,
  parameter bit    DATA0INV  = 1'b0,
  parameter bit    DATA1INV  = 1'b0,
  parameter bit    DATA2INV  = 1'b0,
  parameter bit    DATA3INV  = 1'b0,
  parameter int    LOCK_CNT  = 16,
  parameter int    ERR_LIMIT = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [6:0]  rx_clk_word,
  input  logic [27:0] rx_data_word,
  output logic        vs,
  output logic        hs,
  output logic        de,
  output logic [23:0] rgb,
  output logic        out_valid,
  output logic        locked,
  output logic [2:0]  align_offset,
  output logic [7:0]  lock_loss_cnt
);

  if (PROTOCOL != "VESA" && PROTOCOL != "JEIDA") begin : g_bad_protocol
    $error("lvds_rx_align: PROTOCOL must be \"VESA\" or \"JEIDA\"");
  end
  if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
    $error("lvds_rx_align: LOCK_CNT must be in 1..255");
  end
  if (ERR_LIMIT < 1 || ERR_LIMIT > 15) begin : g_bad_err_limit
    $error("lvds_rx_align: ERR_LIMIT must be in 1..15");
  end

  localparam bit       IS_JEIDA = (PROTOCOL == "JEIDA");
  // Lane 4 is the clock lane; lanes 0..3 are the data lanes
  localparam bit [4:0] INV_MASK = {CLOCKINV, DATA3INV, DATA2INV, DATA1INV, DATA0INV};

  logic [6:0]  lane_in [5];
  logic [13:0] win14   [5];
  logic [6:0]  window  [5];

  for (genvar n = 0; n < 4; n++) begin : g_data_in
    assign lane_in[n] = rx_data_word[7*n +: 7];
  end
  assign lane_in[4] = rx_clk_word;

  for (genvar n = 0; n < 5; n++) begin : g_lane
    lvds_rx_lane_align #(.INV(INV_MASK[n])) u_lane (
      .pclk   (pclk),
      .rst    (rst),
      .en     (rx_valid),
      .sample (lane_in[n]),
      .offset (align_offset),
      .win14  (win14[n]),
      .window (window[n])
    );
  end

  logic vld_p0;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rx_valid;
  end

  // Descending scan so the lowest matching offset wins
  logic       hit_any;
  logic [2:0] hit_k;
  always_comb begin
    hit_any = 1'b0;
    hit_k   = '0;
    for (int k = 6; k >= 0; k--) begin
      if (7'(win14[4] >> (7 - k)) == LVDS_CLK_PATTERN) begin
        hit_any = 1'b1;
        hit_k   = 3'(k);
      end
    end
  end

  logic match_p0;
  assign match_p0 = (window[4] == LVDS_CLK_PATTERN);

  state_t     state;
  logic [7:0] match_cnt;
  logic [3:0] err_cnt;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state         <= SEARCH;
      align_offset  <= '0;
      match_cnt     <= '0;
      err_cnt       <= '0;
      locked        <= 1'b0;
      lock_loss_cnt <= '0;
    end else if (vld_p0) begin
      case (state)
        SEARCH: begin
          if (hit_any) begin
            align_offset <= hit_k;
            match_cnt    <= 8'd1;
            if (LOCK_CNT == 1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (match_p0) begin
            match_cnt <= match_cnt + 8'd1;
            if (match_cnt == 8'(LOCK_CNT - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            state     <= SEARCH;
            match_cnt <= '0;
          end
        end
        LOCKED: begin
          if (match_p0) begin
            err_cnt <= '0;
          end else if (err_cnt == 4'(ERR_LIMIT - 1)) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_cnt   <= '0;
            match_cnt <= '0;
            if (lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end else begin
            err_cnt <= err_cnt + 4'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Stage B: aligned windows plus the lock state seen by this word
  logic        vld_p1;
  logic        lock_p1;
  logic [27:0] data_p1;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      lock_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        lock_p1 <= locked;
        data_p1 <= {window[3], window[2], window[1], window[0]};
      end
    end
  end

  pixel_t pix_p1;
  always_comb pix_p1 = IS_JEIDA ? unmap_jeida(data_p1) : unmap_vesa(data_p1);

  // Stage C: decoded outputs, blanked until lock is established
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      de        <= 1'b0;
      vs        <= 1'b0;
      hs        <= 1'b0;
      rgb       <= '0;
    end else begin
      out_valid <= vld_p1 & lock_p1;
      if (vld_p1) {de, vs, hs, rgb} <= lock_p1 ? pix_p1 : '0;
    end
  end

endmodule

// File: tb/tb_lvds_rx_align.sv
// Bench for lvds_rx_align: VESA, JEIDA and polarity-inverted instances fed the
// same serial pixel stream, checked against a bit-stream reference model.
module tb_lvds_rx_align;

  localparam logic [6:0] PAT       = 7'b1100011;
  localparam int         LOCK_N    = 16;
  localparam int         ERR_N     = 4;
  localparam logic [27:0] LANE2_MASK = 28'h01FC000;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [6:0]  cw = '0, cwi = '0;
  logic [27:0] dv = '0, dj = '0, di = '0;

  logic vs_v, hs_v, de_v, ov_v, lk_v; logic [23:0] rgb_v; logic [2:0] ao_v; logic [7:0] llc_v;
  logic vs_j, hs_j, de_j, ov_j, lk_j; logic [23:0] rgb_j; logic [2:0] ao_j; logic [7:0] llc_j;
  logic vs_i, hs_i, de_i, ov_i, lk_i; logic [23:0] rgb_i; logic [2:0] ao_i; logic [7:0] llc_i;

  always #5 pclk = ~pclk;

  lvds_rx_align #(.PROTOCOL("VESA")) u_vesa (
    .pclk(pclk), .rst(rst), .rx_valid(rx_valid), .rx_clk_word(cw), .rx_data_word(dv),
    .vs(vs_v), .hs(hs_v), .de(de_v), .rgb(rgb_v), .out_valid(ov_v), .locked(lk_v),
    .align_offset(ao_v), .lock_loss_cnt(llc_v));

  lvds_rx_align #(.PROTOCOL("JEIDA")) u_jeida (
    .pclk(pclk), .rst(rst), .rx_valid(rx_valid), .rx_clk_word(cw), .rx_data_word(dj),
    .vs(vs_j), .hs(hs_j), .de(de_j), .rgb(rgb_j), .out_valid(ov_j), .locked(lk_j),
    .align_offset(ao_j), .lock_loss_cnt(llc_j));

  lvds_rx_align #(.PROTOCOL("VESA"), .CLOCKINV(1'b1), .DATA2INV(1'b1)) u_inv (
    .pclk(pclk), .rst(rst), .rx_valid(rx_valid), .rx_clk_word(cwi), .rx_data_word(di),
    .vs(vs_i), .hs(hs_i), .de(de_i), .rgb(rgb_i), .out_valid(ov_i), .locked(lk_i),
    .align_offset(ao_i), .lock_loss_cnt(llc_i));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        v;
    logic        lk;
    logic [26:0] pix;
  } rec_t;
  rec_t rec1, rec2;

  // Reference model: receiver history, lock status and counters
  logic       m_lock;
  int         m_run, m_err, m_loss, m_aoff;
  logic [6:0] m_prev, m_cur;

  // Transmit side: serial stream with k_true leading bits of skew
  int          k_true;
  logic [6:0]  g_cw_prev;
  logic [27:0] g_v_prev, g_j_prev;
  logic [26:0] g_px_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] enc_vesa(input logic [26:0] p, input logic x);
    logic [7:0] r, g, b;
    r = p[23:16]; g = p[15:8]; b = p[7:0];
    return {x, b[7:6], g[7:6], r[7:6], p[26], p[25], p[24], b[5:2], b[1:0], g[5:1], g[0], r[5:0]};
  endfunction

  function automatic logic [27:0] enc_jeida(input logic [26:0] p, input logic x);
    logic [7:0] r, g, b;
    r = p[23:16]; g = p[15:8]; b = p[7:0];
    return {x, b[1:0], g[1:0], r[1:0], p[26], p[25], p[24], b[7:4], b[3:2], g[7:3], g[2], r[7:2]};
  endfunction

  // What the deserialiser delivers when the word boundary lags by k bits
  function automatic logic [6:0] raw7(input logic [6:0] p, input logic [6:0] c, input int k);
    logic [13:0] t;
    t = {p, c} >> k;
    return t[6:0];
  endfunction

  function automatic logic [27:0] raw28(input logic [27:0] p, input logic [27:0] c, input int k);
    logic [27:0] r;
    for (int n = 0; n < 4; n++) r[7*n +: 7] = raw7(p[7*n +: 7], c[7*n +: 7], k);
    return r;
  endfunction

  function automatic logic [6:0] win_at(input logic [13:0] w, input int k);
    return 7'(w >> (7 - k));
  endfunction

  task automatic model_step(input logic [6:0] c);
    logic [13:0] w;
    logic        hit;
    m_prev = m_cur;
    m_cur  = c;
    w      = {m_prev, m_cur};
    hit    = (win_at(w, m_aoff) == PAT);
    if (m_lock) begin
      if (hit) m_err = 0;
      else begin
        m_err++;
        if (m_err == ERR_N) begin
          m_lock = 1'b0; m_err = 0; m_run = 0;
          if (m_loss < 255) m_loss++;
        end
      end
    end else if (m_run > 0) begin
      if (hit) begin
        m_run++;
        if (m_run == LOCK_N) m_lock = 1'b1;
      end else m_run = 0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (win_at(w, k) == PAT) begin
          m_aoff = k; m_run = 1;
          break;
        end
      end
    end
  endtask

  task automatic chk_dut(input string nm, input logic lk, input logic ov, input logic [26:0] px,
                         input logic [2:0] ao, input logic [7:0] llc);
    chk({nm, "_locked"}, 32'(lk), 32'(m_lock));
    chk({nm, "_offset"}, 32'(ao), 32'(m_aoff));
    chk({nm, "_loss"}, 32'(llc), 32'(m_loss));
    if (rec2.v && rec2.lk) begin
      chk({nm, "_out_valid"}, 32'(ov), 32'd1);
      chk({nm, "_pixel"}, 32'(px), 32'(rec2.pix));
    end else begin
      chk({nm, "_out_valid"}, 32'(ov), 32'd0);
      if (rec2.v) chk({nm, "_blank_pixel"}, 32'(px), 32'd0);
    end
  endtask

  task automatic cycle(input logic v, input logic corrupt, input logic [26:0] px);
    logic [6:0]  cword, craw;
    logic [27:0] vw, jw;
    logic [26:0] exp_px;
    craw   = '0;
    exp_px = '0;
    if (v) begin
      cword  = corrupt ? (PAT ^ 7'(1 + $urandom_range(126))) : PAT;
      vw     = enc_vesa(px, 1'($urandom_range(1)));
      jw     = enc_jeida(px, 1'($urandom_range(1)));
      craw   = raw7(g_cw_prev, cword, k_true);
      cw     = craw;
      cwi    = ~craw;
      dv     = raw28(g_v_prev, vw, k_true);
      dj     = raw28(g_j_prev, jw, k_true);
      di     = dv ^ LANE2_MASK;
      exp_px = g_px_prev;
      g_cw_prev = cword; g_v_prev = vw; g_j_prev = jw; g_px_prev = px;
    end else begin
      cw  = 7'($urandom);
      cwi = 7'($urandom);
      dv  = 28'($urandom);
      dj  = 28'($urandom);
      di  = 28'($urandom);
    end
    rx_valid = v;
    @(posedge pclk);
    #1;
    chk_dut("vesa",  lk_v, ov_v, {de_v, vs_v, hs_v, rgb_v}, ao_v, llc_v);
    chk_dut("jeida", lk_j, ov_j, {de_j, vs_j, hs_j, rgb_j}, ao_j, llc_j);
    chk_dut("inv",   lk_i, ov_i, {de_i, vs_i, hs_i, rgb_i}, ao_i, llc_i);
    rec2 = rec1;
    rec1 = '{v: v, lk: m_lock, pix: exp_px};
    if (v) model_step(craw);
  endtask

  task automatic chk_zero(input string nm, input logic lk, input logic ov, input logic [26:0] px,
                          input logic [2:0] ao, input logic [7:0] llc);
    chk({nm, "_rst_locked"}, 32'(lk), 32'd0);
    chk({nm, "_rst_out_valid"}, 32'(ov), 32'd0);
    chk({nm, "_rst_pixel"}, 32'(px), 32'd0);
    chk({nm, "_rst_offset"}, 32'(ao), 32'd0);
    chk({nm, "_rst_loss"}, 32'(llc), 32'd0);
  endtask

  // Asserted between clock edges so the clear must be asynchronous
  task automatic do_reset();
    #2;
    rst = 1'b1;
    rx_valid = 1'b0;
    #1;
    chk_zero("vesa",  lk_v, ov_v, {de_v, vs_v, hs_v, rgb_v}, ao_v, llc_v);
    chk_zero("jeida", lk_j, ov_j, {de_j, vs_j, hs_j, rgb_j}, ao_j, llc_j);
    chk_zero("inv",   lk_i, ov_i, {de_i, vs_i, hs_i, rgb_i}, ao_i, llc_i);
    @(posedge pclk); #1;
    @(posedge pclk); #3;
    rst = 1'b0;
    m_lock = 1'b0; m_run = 0; m_err = 0; m_loss = 0; m_aoff = 0;
    m_prev = '0; m_cur = '0;
    rec1 = '0; rec2 = '0;
    g_cw_prev = '0; g_v_prev = '0; g_j_prev = '0; g_px_prev = '0;
  endtask

  initial begin
    // Skewed by 3 bits, constant pixel
    do_reset();
    k_true = 3;
    repeat (24) cycle(1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 24'h123456});
    chk("t1_locked", 32'(lk_v), 32'd1);
    chk("t1_offset", 32'(ao_v), 32'd3);
    chk("t1_rgb", 32'(rgb_v), 32'h123456);
    chk("t1_sync", 32'({de_v, vs_v, hs_v}), 32'b110);
    chk("t1_inv_rgb", 32'(rgb_i), 32'h123456);
    repeat (20) cycle(1'b1, 1'b0, 27'($urandom));

    // Aligned stream, JEIDA pixel, then random pixels with random L3 bit 6
    do_reset();
    k_true = 0;
    repeat (24) cycle(1'b1, 1'b0, {1'b0, 1'b0, 1'b1, 24'hA5C30F});
    chk("t2_jeida_rgb", 32'(rgb_j), 32'hA5C30F);
    chk("t2_jeida_sync", 32'({de_j, vs_j, hs_j}), 32'b001);
    chk("t2_offset", 32'(ao_j), 32'd0);
    repeat (20) cycle(1'b1, 1'b0, 27'($urandom));

    // Clock-lane corruption: 3 words tolerated, 4 drop lock
    repeat (3) cycle(1'b1, 1'b1, 27'($urandom));
    repeat (6) cycle(1'b1, 1'b0, 27'($urandom));
    chk("t3_still_locked", 32'(lk_v), 32'd1);
    repeat (4) cycle(1'b1, 1'b1, 27'($urandom));
    repeat (2) cycle(1'b1, 1'b0, 27'($urandom));
    chk("t3_dropped", 32'(lk_v), 32'd0);
    chk("t3_loss_cnt", 32'(llc_v), 32'd1);
    repeat (20) cycle(1'b1, 1'b0, 27'($urandom));
    chk("t3_relocked", 32'(lk_v), 32'd1);

    // Valid gaps during CHECK and LOCKED
    do_reset();
    k_true = 5;
    repeat (8) cycle(1'b1, 1'b0, 27'($urandom));
    cycle(1'b0, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b0, 27'($urandom));
    repeat (5) cycle(1'b0, 1'b0, '0);
    repeat (10) cycle(1'b1, 1'b0, 27'($urandom));
    repeat (37) cycle(1'b0, 1'b0, '0);
    repeat (6) cycle(1'b1, 1'b0, 27'($urandom));
    cycle(1'b0, 1'b0, '0);
    repeat (4) cycle(1'b1, 1'b0, 27'($urandom));
    chk("t5_locked", 32'(lk_v), 32'd1);
    chk("t5_offset", 32'(ao_v), 32'd5);

    // Asynchronous reset while locked, then re-lock at a new skew
    do_reset();
    k_true = 2;
    repeat (24) cycle(1'b1, 1'b0, 27'($urandom));
    chk("t6_relocked", 32'(lk_i), 32'd1);
    chk("t6_offset", 32'(ao_i), 32'd2);
    repeat (3) cycle(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
